// File: rtl/class_hvec_search_if.sv
// Handshake and class-memory signal bundle for class_hvec_search.
// slave is the search engine's view; master is the surrounding system's view.
interface class_hvec_search_if #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_FRAMES         = 3,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2
);
  localparam int DIST_W = $clog2(NUM_FRAMES * DI_PARALLEL_W_BITS + 1);

  logic                          query_valid;
  logic                          query_ready;
  logic [DI_PARALLEL_W_BITS-1:0] query_data;
  logic [CLASS_ID_W-1:0]         frame_id;
  logic [FRAME_IDX_W-1:0]        frame_index;
  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in;
  logic                          busy;
  logic                          result_valid;
  logic                          result_ready;
  logic [CLASS_ID_W-1:0]         result_class;
  logic [DIST_W-1:0]             result_dist;

  modport slave (
    input  query_valid, query_data, class_vec_in, result_ready,
    output query_ready, frame_id, frame_index, busy,
           result_valid, result_class, result_dist
  );

  modport master (
    output query_valid, query_data, class_vec_in, result_ready,
    input  query_ready, frame_id, frame_index, busy,
           result_valid, result_class, result_dist
  );
endinterface

// File: rtl/class_hvec_search.sv
// HDC associative search: buffers one query hypervector, then scans every class
// frame by frame and reports the class with the smallest Hamming distance.
module class_hvec_search #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int NUM_CLASSES        = 8,
  parameter int NUM_FRAMES         = 3,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  class_hvec_search_if.slave  bus
);
  localparam int DIST_W = $clog2(NUM_FRAMES * DI_PARALLEL_W_BITS + 1);
  localparam int POP_W  = $clog2(DI_PARALLEL_W_BITS + 1);

  localparam logic [1:0] LOAD   = 2'd0;
  localparam logic [1:0] SEARCH = 2'd1;
  localparam logic [1:0] RESULT = 2'd2;

  localparam logic [FRAME_IDX_W-1:0] LAST_F = FRAME_IDX_W'(NUM_FRAMES - 1);
  localparam logic [CLASS_ID_W-1:0]  LAST_C = CLASS_ID_W'(NUM_CLASSES - 1);

  logic [1:0]                    state;
  logic [FRAME_IDX_W-1:0]        qptr;
  logic [FRAME_IDX_W-1:0]        f;
  logic [CLASS_ID_W-1:0]         c;
  logic [DIST_W-1:0]             acc;
  logic [DIST_W-1:0]             acc_next;
  logic [DIST_W-1:0]             best_dist;
  logic [CLASS_ID_W-1:0]         best_class;
  logic [DI_PARALLEL_W_BITS-1:0] qbuf [NUM_FRAMES];
  logic [DI_PARALLEL_W_BITS-1:0] diff;
  logic [POP_W-1:0]              d;
  logic                          beat;

  assign beat = (state == LOAD) && bus.query_valid;

  // Memory read, XOR, popcount and accumulate all settle within one cycle.
  always_comb begin
    diff = bus.class_vec_in ^ qbuf[f];
    d    = '0;
    for (int unsigned i = 0; i < DI_PARALLEL_W_BITS; i++) begin
      d = d + POP_W'(diff[i]);
    end
    acc_next = ((f == '0) ? '0 : acc) + DIST_W'(d);
  end

  // Query buffer deliberately has no reset; it is always written before use.
  always_ff @(posedge clk) begin
    if (beat) begin
      qbuf[qptr] <= bus.query_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD;
      qptr       <= '0;
      f          <= '0;
      c          <= '0;
      acc        <= '0;
      best_dist  <= '0;
      best_class <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (beat) begin
            if (qptr == LAST_F) begin
              qptr  <= '0;
              f     <= '0;
              c     <= '0;
              state <= SEARCH;
            end else begin
              qptr <= qptr + 1'b1;
            end
          end
        end
        SEARCH: begin
          acc <= acc_next;
          if (f == LAST_F) begin
            // Strict compare: on ties the earlier (lower-index) class wins.
            if ((c == '0) || (acc_next < best_dist)) begin
              best_dist  <= acc_next;
              best_class <= c;
            end
            f <= '0;
            c <= c + 1'b1;
            if (c == LAST_C) begin
              state <= RESULT;
            end
          end else begin
            f <= f + 1'b1;
          end
        end
        RESULT: begin
          if (bus.result_ready) begin
            state <= LOAD;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  assign bus.query_ready  = (state == LOAD);
  assign bus.busy         = (state == SEARCH);
  assign bus.result_valid = (state == RESULT);
  assign bus.frame_id     = (state == SEARCH) ? c : '0;
  assign bus.frame_index  = (state == SEARCH) ? f : '0;
  assign bus.result_class = best_class;
  assign bus.result_dist  = best_dist;
endmodule

// File: doc/class_hvec_search.md
# class_hvec_search

Associative-search engine for HDC inference. It buffers one encoded query hypervector, delivered as `NUM_FRAMES` chunks of `DI_PARALLEL_W_BITS`, then walks the class hypervector memory (`class_hvec_gen`) frame by frame. For each class it accumulates the Hamming distance to the query, and it returns the class with the smallest total distance. It sits between the encoder output and the classification result port, and it is the sole driver of the class memory's `frame_id` / `frame_index` address inputs.

## Interface

Parameters:
- `DI_PARALLEL_W_BITS`, 64: chunk width; must match `class_hvec_gen`.
- `NUM_CLASSES`, 8: number of class hypervectors.
- `NUM_FRAMES`, 3: chunks per hypervector.
- `CLASS_ID_W`, 3: width of `frame_id`; equals $clog2(NUM_CLASSES).
- `FRAME_IDX_W`, 2: width of `frame_index`; equals $clog2(NUM_FRAMES).
- `DIST_W`, derived: $clog2(NUM_FRAMES*DI_PARALLEL_W_BITS+1), which is 8 at the defaults.

Ports:
- `clk`, in, 1: single clock; all state on its rising edge.
- `rst_n`, in, 1: reset; asynchronous, active-low.
- `query_valid`, in, 1: query chunk present.
- `query_ready`, out, 1: block accepts a query chunk.
- `query_data`, in, DI_PARALLEL_W_BITS: query chunk; chunks arrive in order 0..NUM_FRAMES-1.
- `frame_id`, out, CLASS_ID_W: class address to the class memory.
- `frame_index`, out, FRAME_IDX_W: chunk address to the class memory.
- `class_vec_in`, in, DI_PARALLEL_W_BITS: class memory data; combinational response to `frame_id` / `frame_index` in the same cycle.
- `busy`, out, 1: high while in SEARCH.
- `result_valid`, out, 1: result available.
- `result_ready`, in, 1: consumer accepts the result.
- `result_class`, out, CLASS_ID_W: index of the nearest class.
- `result_dist`, out, DIST_W: Hamming distance of that class.

## Operation

The controller has three states.

- **LOAD** (reset state)
  - `query_ready` = 1.
  - Each accepted beat (`query_valid && query_ready`) writes `query_data` into buffer slot `qptr` and increments `qptr`.
  - The beat with `qptr == NUM_FRAMES-1` clears `qptr`, sets `c = 0` and `f = 0`, and moves to SEARCH.
- **SEARCH**
  - `query_ready` = 0 and `busy` = 1.
  - `frame_id` = `c` and `frame_index` = `f`.
  - Each cycle computes `d = popcount(class_vec_in ^ qbuf[f])`, a 7-bit value at default width.
  - `acc <= (f == 0 ? 0 : acc) + d`. The sum is zero-extended to DIST_W and never saturates.
  - When `f == NUM_FRAMES-1`:
    - `tot = acc_next`.
    - If `c == 0` or `tot < best_dist`, then `best_dist <= tot` and `best_class <= c`.
    - The compare is strict, so ties keep the lower class index.
    - `f <= 0` and `c <= c+1`.
  - Otherwise `f <= f+1`.
  - When `c == NUM_CLASSES-1` and `f == NUM_FRAMES-1`, move to RESULT.
- **RESULT**
  - `result_valid` = 1, with `result_class` / `result_dist` driven from `best_class` / `best_dist`.
  - Outputs are held stable until `result_ready`.
  - On handshake, move to LOAD.

General rules:
- Outside SEARCH, `frame_id` and `frame_index` are 0.
- `class_vec_in` is ignored outside SEARCH.
- `query_valid` is ignored outside LOAD; no beat is consumed.
- `result_ready` is ignored outside RESULT.

## Timing

- **Reset values.** Asynchronous assertion of `rst_n` immediately sets:
  - state = LOAD, with `query_ready` = 1;
  - `busy`, `result_valid`, `frame_id`, `frame_index`, `result_class`, `result_dist`, `qptr`, `c`, `f`, `acc` and `best_*` all = 0.
- **Query buffer.** Not reset; its contents are don't-care until written.
- **Reset mid-operation.** A reset during SEARCH or RESULT aborts the operation with no result emitted. The block restarts in LOAD and expects chunk 0 next.
- **Load.** Takes at least NUM_FRAMES accepted beats, at one chunk per cycle; gaps in `query_valid` are allowed.
- **Search.** If the last query beat is accepted at edge E:
  - SEARCH spans the NUM_CLASSES*NUM_FRAMES cycles following E (24 at defaults);
  - `busy` rises at E and falls at E+24;
  - `result_valid` rises at edge E+24.
- **Result handshake.** Completes on the edge where `result_valid && result_ready`. `result_valid` and `busy` are 0 after that edge, and `query_ready` = 1 after that edge.
  - Minimum query-to-query period: NUM_FRAMES + NUM_CLASSES*NUM_FRAMES + 1 cycles (28 at defaults).
- **Combinational path.** `frame_id`/`frame_index` → class memory → XOR → popcount → adder ends at the `acc` and `best_*` registers within one cycle. There is no combinational path from any input to `query_ready` or `result_valid`.

## Test plan

The bench uses a class-memory model that returns `{DI_PARALLEL_W_BITS{pattern(c,f)}}` combinationally.

1. **Exact match.** Model: class 5 chunks equal query chunks A, B, C; every other class returns the bitwise inverse of the query. Expect `result_class` = 5 and `result_dist` = 0, with `result_valid` exactly 24 cycles after the last query beat.
2. **Maximum distance and ties.** Query is all ones; all classes are all zeros. Expect `result_class` = 0 and `result_dist` = 192, which checks width without overflow and lowest-index tie-break.
3. **Strict minimum.** Class c differs from the query in `8-c` bits of frame 2 only. Expect `result_class` = 7 and `result_dist` = 1. The bench checks `frame_id`/`frame_index` sequence (0,0),(0,1),(0,2),(1,0)…(7,2), one pair per cycle.
4. **Backpressure.** Hold `result_ready` = 0 for 10 cycles. Expect outputs stable and `query_ready` = 0. While held, drive `query_valid` = 1: no beat is accepted. Release `result_ready`: `query_ready` = 1 next cycle, and a second query searches correctly.
5. **Input gaps.** Send query beats with 2 idle cycles between them. Expect the same result as the gapless case and `qptr` wrap to 0.
6. **Reset mid-search.** Assert `rst_n` = 0 at SEARCH cycle 10. Expect all outputs 0 immediately and no `result_valid`. After release, a full new query completes with the correct result.
